// File: rtl/llmanager_freelist_pkg.sv
// Shared definitions for the free-page list manager: state encoding and default sizes.
package llmanager_freelist_pkg;

  localparam int unsigned LpszDefault   = 8;
  localparam int unsigned NpagesDefault = 256;

  // Bit positions of the one-hot state register.
  localparam int unsigned StInitIdx  = 0;
  localparam int unsigned StIdleIdx  = 1;
  localparam int unsigned StFetchIdx = 2;

  typedef enum logic [2:0] {
    StInit  = 3'(1 << StInitIdx),
    StIdle  = 3'(1 << StIdleIdx),
    StFetch = 3'(1 << StFetchIdx)
  } state_e;

endpackage

// File: rtl/llmanager_freelist_if.sv
// Reclaim, page-allocation and link-memory signals of the free-list manager.
interface llmanager_freelist_if #(
  parameter int unsigned Lpsz = llmanager_freelist_pkg::LpszDefault
);

  logic            reclaim_srdy;
  logic            reclaim_drdy;
  logic [Lpsz-1:0] reclaim_start_page;
  logic [Lpsz-1:0] reclaim_end_page;

  logic            par_srdy;
  logic            par_drdy;
  logic [Lpsz-1:0] par_page;

  logic            lnp_wr_en;
  logic [Lpsz-1:0] lnp_wr_addr;
  logic [Lpsz-1:0] lnp_wr_data;
  logic            lnp_rd_en;
  logic [Lpsz-1:0] lnp_rd_addr;
  logic [Lpsz-1:0] lnp_rd_data;

  // Free-list manager side.
  modport slave (
    input  reclaim_srdy, reclaim_start_page, reclaim_end_page, par_drdy, lnp_rd_data,
    output reclaim_drdy, par_srdy, par_page,
    output lnp_wr_en, lnp_wr_addr, lnp_wr_data, lnp_rd_en, lnp_rd_addr
  );

  // Reclaim source, page consumer and link memory side.
  modport master (
    output reclaim_srdy, reclaim_start_page, reclaim_end_page, par_drdy, lnp_rd_data,
    input  reclaim_drdy, par_srdy, par_page,
    input  lnp_wr_en, lnp_wr_addr, lnp_wr_data, lnp_rd_en, lnp_rd_addr
  );

endinterface

// File: rtl/llmanager_freelist.sv
// Free-page list manager: splices reclaimed chains onto the tail, hands out pages from the head,
// and initialises the external link memory after reset.
module llmanager_freelist
  import llmanager_freelist_pkg::*;
#(
  parameter int unsigned Lpsz   = LpszDefault,
  parameter int unsigned Npages = NpagesDefault
) (
  input  logic                 clk,
  input  logic                 reset,
  llmanager_freelist_if.slave  bus,
  output logic                 init_done,
  output logic                 free_empty
);

  localparam logic [Lpsz-1:0] LastPage = Lpsz'(Npages - 1);

  state_e          state_q, state_d;
  logic [Lpsz-1:0] head_q, head_d;
  logic [Lpsz-1:0] tail_q, tail_d;
  logic [Lpsz-1:0] init_addr_q, init_addr_d;
  logic            free_empty_q, free_empty_d;
  logic            init_done_q, init_done_d;

  logic            reclaim_drdy;
  logic            par_srdy;
  logic            wr_en;
  logic [Lpsz-1:0] wr_addr;
  logic [Lpsz-1:0] wr_data;
  logic            rd_en;
  logic [Lpsz-1:0] rd_addr;

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    init_addr_d  = init_addr_q;
    free_empty_d = free_empty_q;
    init_done_d  = init_done_q;
    reclaim_drdy = 1'b0;
    par_srdy     = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    rd_en        = 1'b0;
    rd_addr      = '0;

    // Handshake and memory outputs stay quiet while reset is held.
    if (!reset) begin
      unique case (state_q)
        StInit: begin
          wr_en       = 1'b1;
          wr_addr     = init_addr_q;
          wr_data     = init_addr_q + 1'b1;
          init_addr_d = init_addr_q + 1'b1;
          if (init_addr_q == LastPage) begin
            state_d     = StIdle;
            init_done_d = 1'b1;
          end
        end
        StIdle: begin
          reclaim_drdy = 1'b1;
          par_srdy     = !free_empty_q && !bus.reclaim_srdy;
          if (bus.reclaim_srdy) begin
            tail_d = bus.reclaim_end_page;
            if (free_empty_q) begin
              head_d       = bus.reclaim_start_page;
              free_empty_d = 1'b0;
            end else begin
              wr_en   = 1'b1;
              wr_addr = tail_q;
              wr_data = bus.reclaim_start_page;
            end
          end else if (par_srdy && bus.par_drdy) begin
            // The tail's link is stale, so the last page is recognised by head == tail.
            if (head_q == tail_q) begin
              free_empty_d = 1'b1;
            end else begin
              rd_en   = 1'b1;
              rd_addr = head_q;
              state_d = StFetch;
            end
          end
        end
        StFetch: begin
          head_d  = bus.lnp_rd_data;
          state_d = StIdle;
        end
        default: state_d = StInit;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StInit;
      head_q       <= '0;
      tail_q       <= LastPage;
      init_addr_q  <= '0;
      free_empty_q <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      init_addr_q  <= init_addr_d;
      free_empty_q <= free_empty_d;
      init_done_q  <= init_done_d;
    end
  end

  assign bus.reclaim_drdy = reclaim_drdy;
  assign bus.par_srdy     = par_srdy;
  assign bus.par_page     = head_q;
  assign bus.lnp_wr_en    = wr_en;
  assign bus.lnp_wr_addr  = wr_addr;
  assign bus.lnp_wr_data  = wr_data;
  assign bus.lnp_rd_en    = rd_en;
  assign bus.lnp_rd_addr  = rd_addr;
  assign init_done        = init_done_q;
  assign free_empty       = free_empty_q;

endmodule

// File: tb/tb_llmanager_freelist.sv
// Bench for llmanager_freelist: free list modelled as a page queue, checked by a negedge monitor.
module tb_llmanager_freelist;

  localparam int unsigned Lpsz   = 4;
  localparam int unsigned Npages = 16;
  typedef logic [Lpsz-1:0] pg_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic init_done;
  logic free_empty;

  llmanager_freelist_if #(.Lpsz(Lpsz)) bus ();

  llmanager_freelist #(.Lpsz(Lpsz), .Npages(Npages)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .init_done  (init_done),
    .free_empty (free_empty)
  );

  always #5 clk = ~clk;

  // External link memory, one-cycle read latency; the bench side port builds chain links.
  pg_t  mem [Npages];
  logic tb_wr_en;
  pg_t  tb_wr_addr;
  pg_t  tb_wr_data;

  always @(posedge clk) begin
    if (tb_wr_en) mem[tb_wr_addr] <= tb_wr_data;
    if (bus.lnp_wr_en) mem[bus.lnp_wr_addr] <= bus.lnp_wr_data;
    if (bus.lnp_rd_en) bus.lnp_rd_data <= mem[bus.lnp_rd_addr];
  end

  int  total = 0;
  int  bad   = 0;
  pg_t free_q[$];       // reference free list, head first
  pg_t alloc_q[$];      // pages handed out and not yet returned
  pg_t chain_pg_q[$];   // pending reclaim chains (pages)
  int  chain_len_q[$];  // pending reclaim chains (lengths)
  pg_t ch[$];
  int  pop_cnt = 0;
  int  rc_cnt  = 0;
  int  cyc     = 0;
  bit  fetch_exp = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_step();
    bit  exp_ps, exp_wr, exp_rd;
    pg_t wa, wd, ra, pg;
    int  n;
    exp_ps = (free_q.size() != 0) && !bus.reclaim_srdy;
    exp_wr = 1'b0;
    exp_rd = 1'b0;
    wa = '0;
    wd = '0;
    ra = '0;
    chk("idle_reclaim_drdy", int'(bus.reclaim_drdy), 1);
    chk("par_srdy", int'(bus.par_srdy), int'(exp_ps));
    chk("free_empty", int'(free_empty), int'(free_q.size() == 0));
    if (exp_ps) chk("par_page", int'(bus.par_page), int'(free_q[0]));
    if (bus.reclaim_srdy) begin
      n = (chain_len_q.size() != 0) ? chain_len_q.pop_front() : 0;
      if (n > 0) begin
        if (free_q.size() != 0) begin
          exp_wr = 1'b1;
          wa = free_q[$];
          wd = chain_pg_q[0];
        end
        for (int i = 0; i < n; i++) free_q.push_back(chain_pg_q.pop_front());
      end
      rc_cnt++;
    end else if (exp_ps && bus.par_drdy) begin
      pg = free_q.pop_front();
      alloc_q.push_back(pg);
      pop_cnt++;
      if (free_q.size() != 0) begin
        exp_rd    = 1'b1;
        ra        = pg;
        fetch_exp = 1'b1;
      end
    end
    chk("lnp_wr_en", int'(bus.lnp_wr_en), int'(exp_wr));
    if (exp_wr) chk("lnp_wr_addr_data", int'({bus.lnp_wr_addr, bus.lnp_wr_data}), int'({wa, wd}));
    chk("lnp_rd_en", int'(bus.lnp_rd_en), int'(exp_rd));
    if (exp_rd) chk("lnp_rd_addr", int'(bus.lnp_rd_addr), int'(ra));
  endtask

  // Monitor: owns the reference model and compares whenever the DUT is observable.
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_outputs", int'({bus.lnp_wr_en, bus.lnp_wr_addr, bus.lnp_wr_data, bus.lnp_rd_en,
                                 bus.lnp_rd_addr, bus.reclaim_drdy, bus.par_srdy}), 0);
      free_q.delete();
      for (int i = 0; i < Npages; i++) free_q.push_back(pg_t'(i));
      alloc_q.delete();
      cyc       = 0;
      fetch_exp = 1'b0;
    end else begin
      chk("init_done", int'(init_done), int'(cyc >= Npages));
      if (cyc < Npages) begin
        chk("init_write", int'({bus.lnp_wr_en, bus.lnp_wr_addr, bus.lnp_wr_data}),
            int'({1'b1, pg_t'(cyc), pg_t'(cyc + 1)}));
        chk("init_quiet", int'({bus.reclaim_drdy, bus.par_srdy, bus.lnp_rd_en, free_empty}), 0);
        cyc++;
      end else if (fetch_exp) begin
        chk("fetch_quiet", int'({bus.reclaim_drdy, bus.par_srdy, bus.lnp_wr_en, bus.lnp_rd_en}), 0);
        fetch_exp = 1'b0;
      end else begin
        idle_step();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    repeat (ncyc) tick();
    reset = 1'b0;
    repeat (Npages) tick();
  endtask

  task automatic pop_n(input int n);
    int target;
    int budget;
    target = pop_cnt + n;
    budget = 4 * n + 8;
    bus.par_drdy = 1'b1;
    while (pop_cnt < target && budget > 0) begin
      tick();
      budget--;
    end
    chk("pop_wait", pop_cnt, target);
    bus.par_drdy = 1'b0;
  endtask

  task automatic take(input pg_t p);
    for (int i = 0; i < alloc_q.size(); i++) begin
      if (alloc_q[i] == p) begin
        alloc_q.delete(i);
        break;
      end
    end
  endtask

  task automatic pick_chain(input int len);
    int j;
    ch.delete();
    for (int i = 0; i < len; i++) begin
      j = $urandom_range(0, alloc_q.size() - 1);
      ch.push_back(alloc_q[j]);
      alloc_q.delete(j);
    end
  endtask

  // Link the chain in memory, then offer it on the reclaim port.
  task automatic reclaim(input bit par_too);
    int rc0;
    int budget;
    rc0    = rc_cnt;
    budget = 12;
    for (int i = 0; i + 1 < ch.size(); i++) begin
      tb_wr_en   = 1'b1;
      tb_wr_addr = ch[i];
      tb_wr_data = ch[i+1];
      tick();
    end
    tb_wr_en = 1'b0;
    chain_len_q.push_back(ch.size());
    foreach (ch[i]) chain_pg_q.push_back(ch[i]);
    bus.reclaim_start_page = ch[0];
    bus.reclaim_end_page   = ch[$];
    bus.reclaim_srdy       = 1'b1;
    bus.par_drdy           = par_too;
    while (rc_cnt == rc0 && budget > 0) begin
      tick();
      budget--;
    end
    chk("reclaim_wait", rc_cnt, rc0 + 1);
    bus.reclaim_srdy = 1'b0;
    bus.par_drdy     = 1'b0;
  endtask

  initial begin
    int m;
    bus.reclaim_srdy       = 1'b0;
    bus.reclaim_start_page = '0;
    bus.reclaim_end_page   = '0;
    bus.par_drdy           = 1'b0;
    tb_wr_en               = 1'b0;
    tb_wr_addr             = '0;
    tb_wr_data             = '0;

    do_reset(3);
    pop_n(3);
    pop_n(free_q.size());
    repeat (3) tick();
    ch = {pg_t'(5), pg_t'(6), pg_t'(7)};
    foreach (ch[i]) take(ch[i]);
    reclaim(1'b0);
    pop_n(3);

    do_reset(1);
    pop_n(14);
    ch = {pg_t'(2), pg_t'(3), pg_t'(4)};
    foreach (ch[i]) take(ch[i]);
    reclaim(1'b0);
    pop_n(5);

    do_reset(1);
    pop_n(4);
    ch = {pg_t'(1), pg_t'(3)};
    foreach (ch[i]) take(ch[i]);
    reclaim(1'b1);
    pop_n(3);

    // Reset lands in the fetch cycle of this pop.
    pop_n(1);
    do_reset(1);
    pop_n(3);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) != 0 && free_q.size() != 0) begin
        m = (free_q.size() < 4) ? free_q.size() : 4;
        pop_n($urandom_range(1, m));
      end else if (alloc_q.size() != 0) begin
        m = (alloc_q.size() < 4) ? alloc_q.size() : 4;
        pick_chain($urandom_range(1, m));
        reclaim(1'($urandom_range(0, 1)));
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    pop_n(free_q.size());
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
